// File: rtl/dmux8way16_stream.sv
// Registered 1-to-8 stream demultiplexer: one producer handshake fans out into
// eight one-entry holding registers, each drained by its own consumer handshake.
module dmux8way16_stream #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [2:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [8*WIDTH-1:0]   out_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    output logic [CNT_W-1:0]     count
);

    logic [7:0]            v_q, v_d;
    logic [7:0][WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  accept;

    // A full channel can still take a word on the edge its consumer drains it.
    assign in_ready = ~v_q[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        v_d   = v_q & ~out_ready;
        d_d   = d_q;
        cnt_d = cnt_q;
        if (accept) begin
            v_d[in_sel] = 1'b1;
            d_d[in_sel] = in_data;
            cnt_d       = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = v_q;
    assign out_data  = d_q;
    assign count     = cnt_q;

endmodule

// File: doc/dmux8way16_stream.md
Name: dmux8way16_stream

Overview:
Registered, flow-controlled 1-to-8 demultiplexer, the distributing counterpart of the 8-way 16-bit mux. It accepts one 16-bit word per cycle with a 3-bit channel select over a valid/ready handshake. Each word is steered into a one-entry holding register for the selected channel, and each of the eight channels drains independently through its own valid/ready handshake. It sits between a single producer (e.g. the CPU write path) and eight consumers (peripheral or register-bank ports).

Parameters:
WIDTH, 16, data word width per channel
CNT_W, 16, width of the accepted-word counter

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous, active-low reset
in_data  input  WIDTH  word to route
in_sel  input  3  destination channel 0..7 (0=a … 7=h)
in_valid  input  1  producer offers in_data/in_sel
in_ready  output  1  block accepts this cycle
out_data  output  8*WIDTH  packed channel data; channel k occupies bits [WIDTH*k+WIDTH-1 : WIDTH*k]
out_valid  output  8  per-channel holding register full
out_ready  input  8  per-channel consumer ready
count  output  CNT_W  total words accepted since reset

Behaviour:
- Reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low. On assertion, immediately (without waiting for a clock edge):
  - out_valid = 8'h00
  - every out_data slice = 0
  - count = 0
- Per channel k: holds a full flag v[k] and a data register d[k]. out_valid[k] = v[k]; out_data slice k = d[k].
- in_ready = ~v[in_sel] | out_ready[in_sel].
  - Combinational from state, in_sel and out_ready only.
  - Never depends on in_valid.
- Accept: an accept occurs when in_valid & in_ready at a rising edge. Then:
  - d[in_sel] <= in_data
  - v[in_sel] <= 1
  - count <= count + 1, wrapping from all-ones to 0.
  - Latency from accept to out_valid[in_sel] = 1 cycle.
- Drain: channel k drains when out_valid[k] & out_ready[k] at a rising edge. Then v[k] <= 0, unless the same edge accepts a word for channel k.
- Same edge, same channel (drain k and accept into k):
  - v[k] stays 1 and d[k] takes the new word.
  - Sustains one word per cycle into a single channel with no bubbles.
- Channel independence:
  - Drains on any set of channels may occur on the same edge as an accept to any channel.
  - Channels not selected by in_sel are unaffected by the input side.
- Full, blocked channel: v[in_sel]=1 and out_ready[in_sel]=0 gives in_ready=0.
  - The word is not taken and count does not change.
  - The producer must hold in_data/in_sel stable until accepted.
  - Other channels continue to drain.
- Hold: while out_valid[k] & ~out_ready[k], slice k and out_valid[k] are stable.
- Empty channel: when v[k]=0, slice k keeps its last delivered value (0 after reset). Consumers ignore it.
- in_valid=0: no state change on the input side; in_sel is don't-care.
- Reset mid-operation: all pending words are discarded with no partial delivery. The first accept after release behaves exactly as after power-up reset.
- No illegal states. Every in_sel value 0..7 is valid.

Test Plan:
- Reset: hold rst_n=0 with random inputs → out_valid=8'h00, all slices 0, count=0. Asynchronous clear is checked mid-cycle.
- Single route: in_data=16'hA5C3, in_sel=5, in_valid=1 for one edge, out_ready=0 → in_ready was 1. Next cycle out_valid=8'b0010_0000, slice 5=16'hA5C3, count=1. Other slices stay 0.
- Backpressure: channel 2 full, out_ready[2]=0, in_sel=2, in_valid=1 → in_ready=0, count unchanged, slice 2 stable for 10 cycles. Then assert out_ready[2] → new word accepted on that edge and delivered next cycle.
- Full throughput: in_sel=7, out_ready[7]=1, 16 consecutive words 1..16 → in_ready=1 every cycle. Channel 7 presents each word exactly one cycle later, in order, with no gaps. count=16.
- Sweep: 100 iterations of 8 random words (mirroring the mux bench), one per sel 0..7, all out_ready=1 → slice k equals the word sent with sel=k one cycle later. count=800. No mismatches reported; print "passed".
- Counter wrap and mid-run reset: preload count to 16'hFFFF via 65535 accepts, then one more accept → count=0. Pulse rst_n low while channels 1 and 4 are full → both out_valid clear immediately, and the next accept resumes normally.
